axi_irq_service_master: RTL and testbench
=========================================

AXI_IRQ_SERVICE_MASTER -- requirements
Module: axi_irq_service_master

Interface
REQ-001 SHALL have parameter C_M00_AXI_ADDR_WIDTH, default 4, AXI4-Lite address width.
REQ-002 SHALL have parameter C_M00_AXI_DATA_WIDTH, default 32, AXI4-Lite data width.
REQ-003 SHALL have parameter TIMEOUT_MAX, default 1024, handshake timeout in cycles.
REQ-004 SHALL have the following ports, one clock, synchronous active-high reset:
- m00_axi_aclk  in  1  sole clock.
- m00_axi_areset  in  1  synchronous, active-high reset.
- enable  in  1  permits the service loop.
- irq  in  1  peripheral interrupt, level, synchronous to m00_axi_aclk.
- m00_axi_awaddr/awprot/awvalid  out  ADDR/3/1; m00_axi_awready  in  1  write address.
- m00_axi_wdata/wstrb/wvalid  out  DATA/DATA/8/1; m00_axi_wready  in  1  write data.
- m00_axi_bresp  in  2; m00_axi_bvalid  in  1; m00_axi_bready  out  1  write response.
- m00_axi_araddr/arprot/arvalid  out  ADDR/3/1; m00_axi_arready  in  1  read address.
- m00_axi_rdata  in  DATA; m00_axi_rresp  in  2; m00_axi_rvalid  in  1; m00_axi_rready  out  1  read data.
- data_out  out  DATA  serviced data word; data_valid  out  1; data_ready  in  1.
- busy  out  1  high when not in IDLE; err  out  1  sticky error; irq_count  out  16  serviced interrupts.

Function
REQ-005 SHALL use peripheral map DATA=0x0, CTRL=0x4 (bit0 INT_CLEAR, bit1 RESET_STATE), STATUS=0x8 (bit0 interrupt pending), INT_ENABLE=0xC.
REQ-006 SHALL implement states INIT, IDLE, RD_STATUS, RD_DATA, PUSH, WR_CLEAR, WAIT_LOW, WR_RESET.
REQ-007 INIT SHALL write 0x1 to INT_ENABLE once after reset, then enter IDLE.
REQ-008 IDLE SHALL move to RD_STATUS in the cycle after irq=1 and enable=1 are both sampled.
REQ-009 RD_STATUS: if rdata[0]=1 SHALL go to RD_DATA, else SHALL count no interrupt and go to WR_RESET (spurious).
REQ-010 RD_DATA SHALL capture rdata into data_out and go to PUSH; PUSH SHALL hold data_valid=1 and data_out stable until data_ready=1, then go to WR_CLEAR.
REQ-011 WR_CLEAR SHALL write 0x1 to CTRL; WAIT_LOW SHALL wait for irq=0; WR_RESET SHALL write 0x2 to CTRL, then IDLE with irq_count+1 (wrap 0xFFFF->0) if non-spurious.
REQ-012 Writes SHALL assert awvalid and wvalid in the same cycle, deassert each independently on its own ready, keep bready=1 until bvalid; wstrb=all ones, awprot=arprot=0.
REQ-013 Reads SHALL hold arvalid until arready, keep rready=1 until rvalid, capture rdata on rvalid.
REQ-014 Exactly one AXI transaction SHALL be outstanding at any time; address/data SHALL be stable while valid=1.
REQ-015 bresp or rresp not OKAY SHALL set err and abort to WR_RESET (INIT failure: retry INIT).
REQ-016 enable=0 SHALL only block leaving IDLE; an in-progress service SHALL complete.

Reset
REQ-017 On m00_axi_areset=1 at a clock edge: state=INIT, all valid outputs=0, bready=rready=0, data_out=0, err=0, irq_count=0, busy=1 (INIT counts as busy).
REQ-018 Reset mid-transaction SHALL drop all valids the next edge without waiting for handshakes.

Configuration
REQ-019 Macro AXI_IRQ_SVC_TIMEOUT_EN defined: each AXI wait and WAIT_LOW SHALL time out after TIMEOUT_MAX cycles, set err, go to WR_RESET (from WR_RESET timeout: IDLE).
REQ-020 Macro undefined: no timeout counter; waits are unbounded; err set only by bad responses.

Structure
REQ-021 Package axi_irq_svc_pkg SHALL hold register addresses, CTRL bit constants, resp codes and the state enum.
REQ-022 Single-transaction AXI4-Lite engine SHALL be sub-module axi_lite_master_if (req/we/addr/wdata in; done/rdata/resp out).

Verification
REQ-023 Reset release -> one write 0xC<=0x1, then IDLE, busy=0.
REQ-024 Slave DATA=0xA5A5A5A5, irq rises -> reads 0x8 (0x1), reads 0x0, data_out=0xA5A5A5A5 valid; writes 0x4<=0x1, after irq falls 0x4<=0x2; irq_count=1.
REQ-025 data_ready held 0 for 50 cycles -> data_valid stays 1, data_out stable, no CTRL write until ready.
REQ-026 STATUS returns 0x0 on irq -> no DATA read, 0x4<=0x2 only, irq_count unchanged.
REQ-027 rresp=SLVERR on STATUS read -> err=1 sticky, 0x4<=0x2, IDLE.
REQ-028 With AXI_IRQ_SVC_TIMEOUT_EN, TIMEOUT_MAX=100, awready never asserted -> err=1 after 100 cycles, state IDLE.

Source files
------------

// File: rtl/axi_irq_svc_pkg.sv
// Shared constants for the interrupt service master: peripheral register map,
// CTRL/STATUS bit values, AXI response codes and the state enums.
package axi_irq_svc_pkg;

  localparam logic [7:0] REG_DATA   = 8'h0;
  localparam logic [7:0] REG_CTRL   = 8'h4;
  localparam logic [7:0] REG_STATUS = 8'h8;
  localparam logic [7:0] REG_INT_EN = 8'hC;

  localparam logic [31:0] CTRL_INT_CLEAR   = 32'h1;
  localparam logic [31:0] CTRL_RESET_STATE = 32'h2;
  localparam logic [31:0] INT_EN_ALL       = 32'h1;
  localparam int          STATUS_PENDING_BIT = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_STATUS,
    ST_RD_DATA,
    ST_PUSH,
    ST_WR_CLEAR,
    ST_WAIT_LOW,
    ST_WR_RESET
  } svc_state_e;

  typedef enum logic [1:0] {
    MST_IDLE,
    MST_WR,
    MST_RD
  } mst_state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// Single-transaction AXI4-Lite master engine: one read or write per req pulse,
// done_o is a one-cycle strobe coincident with the B/R handshake.
module axi_lite_master_if
  import axi_irq_svc_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                abort_i,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          resp_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [2:0]          awprot_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [2:0]          arprot_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  mst_state_e        state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_o    = 1'b0;
    resp_o    = RESP_OKAY;
    unique case (state_q)
      MST_IDLE: begin
        if (req_i) begin
          addr_d = addr_i;
          if (we_i) begin
            wdata_d   = wdata_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = MST_WR;
          end else begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = MST_RD;
          end
        end
      end
      MST_WR: begin
        // AW and W retire independently; B closes the transaction.
        if (awready_i) awvalid_d = 1'b0;
        if (wready_i)  wvalid_d  = 1'b0;
        if (bvalid_i) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          done_o    = 1'b1;
          resp_o    = bresp_i;
          state_d   = MST_IDLE;
        end
      end
      MST_RD: begin
        if (arready_i) arvalid_d = 1'b0;
        if (rvalid_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          done_o    = 1'b1;
          resp_o    = rresp_i;
          state_d   = MST_IDLE;
        end
      end
      default: state_d = MST_IDLE;
    endcase
    if (abort_i) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      state_d   = MST_IDLE;
    end
  end

  assign rdata_o   = rdata_i;
  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign awprot_o  = 3'b000;
  assign arprot_o  = 3'b000;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = '1;
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

endmodule

// File: rtl/axi_irq_service_master.sv
// Interrupt-driven AXI4-Lite service loop: read STATUS/DATA, hand the word out,
// clear and re-arm the peripheral. Define AXI_IRQ_SVC_TIMEOUT_EN for wait timeouts.
module axi_irq_service_master
  import axi_irq_svc_pkg::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 4,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_MAX          = 1024
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_areset,
  input  logic                                enable,
  input  logic                                irq,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,
  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     data_out,
  output logic                                data_valid,
  input  logic                                data_ready,
  output logic                                busy,
  output logic                                err,
  output logic [15:0]                         irq_count
);

  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;

  svc_state_e    state_q, state_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          err_q, err_d;
  logic [15:0]   irq_count_q, irq_count_d;
  logic          count_q, count_d;
  logic          pend_q, pend_d;

  logic          txn_state, txn_req, txn_we, txn_done, txn_ok, txn_abort, tmo_fire;
  logic [AW-1:0] txn_addr;
  logic [DW-1:0] txn_wdata, txn_rdata;
  logic [1:0]    txn_resp;

  assign txn_state = (state_q == ST_INIT) || (state_q == ST_RD_STATUS) ||
                     (state_q == ST_RD_DATA) || (state_q == ST_WR_CLEAR) ||
                     (state_q == ST_WR_RESET);
  assign txn_req   = txn_state && !pend_q;
  assign txn_ok    = (txn_resp == RESP_OKAY);
  assign txn_abort = tmo_fire;

`ifdef AXI_IRQ_SVC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_MAX + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          waiting;

  assign waiting  = txn_state || (state_q == ST_WAIT_LOW);
  assign tmo_fire = waiting && (tmo_q == TW'(TIMEOUT_MAX - 1)) && !txn_done &&
                    !((state_q == ST_WAIT_LOW) && !irq);
  assign tmo_d    = (state_d != state_q || !waiting) ? '0 : tmo_q + TW'(1);

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) tmo_q <= '0;
    else                tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_q     <= ST_INIT;
      data_out_q  <= '0;
      err_q       <= 1'b0;
      irq_count_q <= '0;
      count_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      err_q       <= err_d;
      irq_count_q <= irq_count_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (txn_req) pend_d = 1'b1;
    if (txn_done || txn_abort) pend_d = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    err_d       = err_q;
    irq_count_d = irq_count_q;
    count_d     = count_q;
    txn_we      = 1'b0;
    txn_addr    = '0;
    txn_wdata   = '0;
    unique case (state_q)
      ST_INIT: begin
        txn_we    = 1'b1;
        txn_addr  = AW'(REG_INT_EN);
        txn_wdata = DW'(INT_EN_ALL);
        if (txn_done) begin
          if (txn_ok) state_d = ST_IDLE;
          else        err_d   = 1'b1;
        end
      end
      ST_IDLE: if (irq && enable) state_d = ST_RD_STATUS;
      ST_RD_STATUS: begin
        txn_addr = AW'(REG_STATUS);
        if (txn_done) begin
          count_d = 1'b0;
          if (!txn_ok) begin
            err_d   = 1'b1;
            state_d = ST_WR_RESET;
          end else if (txn_rdata[STATUS_PENDING_BIT]) begin
            state_d = ST_RD_DATA;
          end else begin
            state_d = ST_WR_RESET;
          end
        end
      end
      ST_RD_DATA: begin
        txn_addr = AW'(REG_DATA);
        if (txn_done) begin
          if (!txn_ok) begin
            err_d   = 1'b1;
            state_d = ST_WR_RESET;
          end else begin
            data_out_d = txn_rdata;
            count_d    = 1'b1;
            state_d    = ST_PUSH;
          end
        end
      end
      ST_PUSH: if (data_ready) state_d = ST_WR_CLEAR;
      ST_WR_CLEAR: begin
        txn_we    = 1'b1;
        txn_addr  = AW'(REG_CTRL);
        txn_wdata = DW'(CTRL_INT_CLEAR);
        if (txn_done) begin
          if (!txn_ok) begin
            err_d   = 1'b1;
            count_d = 1'b0;
            state_d = ST_WR_RESET;
          end else begin
            state_d = ST_WAIT_LOW;
          end
        end
      end
      ST_WAIT_LOW: if (!irq) state_d = ST_WR_RESET;
      ST_WR_RESET: begin
        txn_we    = 1'b1;
        txn_addr  = AW'(REG_CTRL);
        txn_wdata = DW'(CTRL_RESET_STATE);
        if (txn_done) begin
          count_d = 1'b0;
          state_d = ST_IDLE;
          if (!txn_ok)      err_d       = 1'b1;
          else if (count_q) irq_count_d = irq_count_q + 16'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    // A stalled wait counts as a failed service; a stalled re-arm gives up to IDLE.
    if (tmo_fire) begin
      err_d   = 1'b1;
      count_d = 1'b0;
      state_d = (state_q == ST_WR_RESET) ? ST_IDLE : ST_WR_RESET;
    end
  end

  axi_lite_master_if #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_axi (
    .clk_i     (m00_axi_aclk),
    .rst_i     (m00_axi_areset),
    .req_i     (txn_req),
    .we_i      (txn_we),
    .addr_i    (txn_addr),
    .wdata_i   (txn_wdata),
    .abort_i   (txn_abort),
    .done_o    (txn_done),
    .rdata_o   (txn_rdata),
    .resp_o    (txn_resp),
    .awaddr_o  (m00_axi_awaddr),
    .awprot_o  (m00_axi_awprot),
    .awvalid_o (m00_axi_awvalid),
    .awready_i (m00_axi_awready),
    .wdata_o   (m00_axi_wdata),
    .wstrb_o   (m00_axi_wstrb),
    .wvalid_o  (m00_axi_wvalid),
    .wready_i  (m00_axi_wready),
    .bresp_i   (m00_axi_bresp),
    .bvalid_i  (m00_axi_bvalid),
    .bready_o  (m00_axi_bready),
    .araddr_o  (m00_axi_araddr),
    .arprot_o  (m00_axi_arprot),
    .arvalid_o (m00_axi_arvalid),
    .arready_i (m00_axi_arready),
    .rdata_i   (m00_axi_rdata),
    .rresp_i   (m00_axi_rresp),
    .rvalid_i  (m00_axi_rvalid),
    .rready_o  (m00_axi_rready)
  );

  assign data_out   = data_out_q;
  assign data_valid = (state_q == ST_PUSH);
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;
  assign irq_count  = irq_count_q;

endmodule

// File: tb/tb_axi_irq_service_master.sv
// Directed bench for axi_irq_service_master with an AXI4-Lite slave model and
// transaction/data scoreboards.
module tb_axi_irq_service_master;
  import axi_irq_svc_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
`ifdef AXI_IRQ_SVC_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          irq = 1'b0;
  logic          data_ready = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic          bvalid = 1'b0, rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] data_out;
  logic          data_valid, busy, err;
  logic [15:0]   irq_count;

  always #5 clk = ~clk;

  axi_irq_service_master #(
    .C_M00_AXI_ADDR_WIDTH (AW),
    .C_M00_AXI_DATA_WIDTH (DW),
    .TIMEOUT_MAX          (TMO)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_areset  (rst),
    .enable          (enable),
    .irq             (irq),
    .m00_axi_awaddr  (awaddr),
    .m00_axi_awprot  (awprot),
    .m00_axi_awvalid (awvalid),
    .m00_axi_awready (awready),
    .m00_axi_wdata   (wdata),
    .m00_axi_wstrb   (wstrb),
    .m00_axi_wvalid  (wvalid),
    .m00_axi_wready  (wready),
    .m00_axi_bresp   (bresp),
    .m00_axi_bvalid  (bvalid),
    .m00_axi_bready  (bready),
    .m00_axi_araddr  (araddr),
    .m00_axi_arprot  (arprot),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .busy            (busy),
    .err             (err),
    .irq_count       (irq_count)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic log_txn(input txn_t obs);
    txn_t e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL unexpected_txn: observed %0h expected none", obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("txn", 64'(obs), 64'(e));
    end
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  // Slave model: readies and responses change on the falling edge only.
  logic [DW-1:0] regs [4];
  logic          got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  logic          b_fire = 1'b0, r_fire = 1'b0;
  logic [AW-1:0] aw_a = '0, ar_a = '0;
  logic [DW-1:0] w_d = '0;
  logic          aw_block = 1'b0, ar_block = 1'b0, status_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      bvalid = 1'b0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
      b_fire = 1'b0; r_fire = 1'b0;
    end else begin
      if (b_fire) bvalid = 1'b0;
      if (r_fire) rvalid = 1'b0;
      if (got_aw && got_w && !bvalid) begin
        bvalid = 1'b1; bresp = RESP_OKAY;
        got_aw = 1'b0; got_w = 1'b0;
        log_txn({1'b1, aw_a, w_d});
      end
      if (got_ar && !rvalid) begin
        rvalid = 1'b1;
        rdata  = regs[ar_a[3:2]];
        rresp  = (status_err && ar_a == 4'h8) ? RESP_SLVERR : RESP_OKAY;
        got_ar = 1'b0;
        log_txn({1'b0, ar_a, 32'h0});
      end
      awready = !got_aw && !aw_block && ($urandom_range(0, 3) != 0);
      if (awvalid && awready) begin
        got_aw = 1'b1; aw_a = awaddr;
        check("awprot", 64'(awprot), 64'd0);
      end
      wready = !got_w && ($urandom_range(0, 3) != 0);
      if (wvalid && wready) begin
        got_w = 1'b1; w_d = wdata;
        check("wstrb", 64'(wstrb), 64'hF);
      end
      arready = !got_ar && !ar_block && ($urandom_range(0, 3) != 0);
      if (arvalid && arready) begin
        got_ar = 1'b1; ar_a = araddr;
        check("arprot", 64'(arprot), 64'd0);
      end
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst && data_valid && data_ready) begin
      n_cmp++;
      assert (exp_data_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_data: observed %0h expected none", data_out);
      end
      if (exp_data_q.size() != 0) check("data_out", 64'(data_out), 64'(exp_data_q.pop_front()));
    end
  end

  task automatic wait_left(input int left, input int budget, input string tag);
    int i = 0;
    while (exp_q.size() > left && i < budget) begin @(negedge clk); i++; end
    n_cmp++;
    assert (exp_q.size() <= left) else begin
      n_err++;
      $error("FAIL %s: observed %0d outstanding expected %0d", tag, exp_q.size(), left);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    while ((busy || exp_q.size() != 0) && i < budget) begin @(negedge clk); i++; end
    n_cmp++;
    assert (!busy && exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s: observed busy=%0d outstanding=%0d expected busy=0 outstanding=0",
             tag, busy, exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    regs[0] = 32'hA5A5A5A5; regs[1] = 32'h0; regs[2] = 32'h1; regs[3] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, data_valid}), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(irq_count), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);

    // INIT enables the peripheral interrupt
    exp_wr(4'hC, 32'h1);
    rst = 1'b0;
    wait_idle(200, "init_idle");
    check("init_busy", 64'(busy), 64'd0);

    // Normal service
    enable = 1'b1; data_ready = 1'b1;
    exp_rd(4'h8); exp_rd(4'h0); exp_wr(4'h4, 32'h1); exp_wr(4'h4, 32'h2);
    exp_data_q.push_back(32'hA5A5A5A5);
    irq = 1'b1;
    wait_left(1, 300, "svc_clear");
    repeat (10) @(negedge clk);
    check("hold_while_irq", 64'(exp_q.size()), 64'd1);
    irq = 1'b0;
    wait_idle(200, "svc_idle");
    check("svc_count", 64'(irq_count), 64'd1);
    check("svc_data_drained", 64'(exp_data_q.size()), 64'd0);
    check("svc_err", 64'(err), 64'd0);

    // Consumer back-pressure
    regs[0] = 32'h12345678; data_ready = 1'b0;
    exp_rd(4'h8); exp_rd(4'h0);
    exp_data_q.push_back(32'h12345678);
    irq = 1'b1;
    i = 0;
    while (!data_valid && i < 300) begin @(negedge clk); i++; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("stall_hold", 64'({data_valid, data_out}), 64'({1'b1, 32'h12345678}));
    end
    check("stall_no_ctrl", 64'(exp_q.size()), 64'd0);
    exp_wr(4'h4, 32'h1); exp_wr(4'h4, 32'h2);
    data_ready = 1'b1;
    wait_left(1, 300, "stall_clear");
    irq = 1'b0;
    wait_idle(200, "stall_idle");
    check("stall_count", 64'(irq_count), 64'd2);
    check("stall_data_drained", 64'(exp_data_q.size()), 64'd0);

    // Spurious interrupt: STATUS reads 0
    regs[2] = 32'h0;
    exp_rd(4'h8); exp_wr(4'h4, 32'h2);
    irq = 1'b1;
    wait_left(1, 300, "spur_status");
    irq = 1'b0;
    wait_idle(200, "spur_idle");
    check("spur_count", 64'(irq_count), 64'd2);
    check("spur_err", 64'(err), 64'd0);

    // SLVERR on STATUS read
    regs[2] = 32'h1; status_err = 1'b1;
    exp_rd(4'h8); exp_wr(4'h4, 32'h2);
    irq = 1'b1;
    wait_left(1, 300, "slverr_status");
    irq = 1'b0;
    wait_idle(200, "slverr_idle");
    check("slverr_err", 64'(err), 64'd1);
    check("slverr_count", 64'(irq_count), 64'd2);
    status_err = 1'b0;
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);

    // enable=0 keeps the loop in IDLE
    enable = 1'b0; irq = 1'b1;
    repeat (20) @(negedge clk);
    check("disabled_busy", 64'(busy), 64'd0);
    check("disabled_no_txn", 64'({arvalid, awvalid}), 64'd0);
    irq = 1'b0; enable = 1'b1;
    @(negedge clk);

    // Reset while a read address is stalled
    ar_block = 1'b1; irq = 1'b1;
    repeat (10) @(negedge clk);
    check("stuck_arvalid", 64'({arvalid, busy}), 64'b11);
    rst = 1'b1; irq = 1'b0;
    @(negedge clk);
    check("midrst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, data_valid}), 64'd0);
    check("midrst_state", 64'({busy, err, irq_count}), 64'({1'b1, 1'b0, 16'd0}));
    ar_block = 1'b0;
    exp_wr(4'hC, 32'h1);
    rst = 1'b0;
    wait_idle(200, "midrst_idle");
    check("midrst_count", 64'(irq_count), 64'd0);

`ifdef AXI_IRQ_SVC_TIMEOUT_EN
    // awready never asserted: INIT and then the re-arm write both time out
    aw_block = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("tmo_err_early", 64'(err), 64'd0);
    i = 0;
    while (!err && i < 100) begin @(negedge clk); i++; end
    check("tmo_err", 64'(err), 64'd1);
    i = 0;
    while (busy && i < 300) begin @(negedge clk); i++; end
    check("tmo_idle", 64'({busy, err}), 64'b01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
